// File: rtl/alu_seq_pkg.sv
//------------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the execute-stage ALU: opcode encodings, flag bit
// positions inside the {C,V,Z,N} flag word, FSM state encoding, and a helper
// that packs individual flag bits into the flag word.
//------------------------------------------------------------------------------
package alu_seq_pkg;

   // Opcodes (4-bit). Codes 4'hC..4'hF are undefined.
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_ADC = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_SBC = 4'h3;
   localparam logic [3:0] OP_CMP = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_OR  = 4'h6;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_MOV = 4'h8;   // result = value2
   localparam logic [3:0] OP_SHL = 4'h9;
   localparam logic [3:0] OP_SHR = 4'hA;
   localparam logic [3:0] OP_MUL = 4'hB;

   // Bit positions inside the flag word {C,V,Z,N}.
   localparam int FLAG_C = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                             input logic z, input logic n);
      return {c, v, z, n};
   endfunction

endpackage

// File: rtl/alu_seq_mul.sv
//------------------------------------------------------------------------------
// alu_seq_mul
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             load operands a/b (product register cleared)
//   run               advance one step this cycle
//   a, b              multiplicand / multiplier
//   done              high in the cycle whose step completes the product
//   prod_hi, prod_lo  product including the current step (valid with done)
// The product outputs are the combinational result of the step being taken,
// so the parent can register the final product on the same edge as done.
//------------------------------------------------------------------------------
module alu_seq_mul #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             run,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [CNT_W-1:0]   count_reg;
   logic [WIDTH-1:0]   mcand_reg;
   // Upper half accumulates partial sums; lower half initially holds the
   // multiplier and is consumed from bit 0 as the register shifts right.
   logic [2*WIDTH-1:0] prod_reg;
   logic [2*WIDTH-1:0] prod_next;
   logic [WIDTH:0]     step_sum;

   always_comb begin
      step_sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                + (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
      prod_next = {step_sum, prod_reg[WIDTH-1:1]};
   end

   assign done    = run && (count_reg == CNT_W'(WIDTH - 1));
   assign prod_hi = prod_next[2*WIDTH-1:WIDTH];
   assign prod_lo = prod_next[WIDTH-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
         mcand_reg <= '0;
         prod_reg  <= '0;
      end else if (start) begin
         count_reg <= '0;
         mcand_reg <= a;
         prod_reg  <= {{WIDTH{1'b0}}, b};
      end else if (run) begin
         count_reg <= count_reg + CNT_W'(1);
         prod_reg  <= prod_next;
      end
   end

endmodule

// File: rtl/alu_seq.sv
//------------------------------------------------------------------------------
// alu_seq
// Registered, valid/ready handshaked ALU for the execute stage. Holds the
// architectural flag register {C,V,Z,N}; ADC/SBC take carry from it.
// Optional feature macro: ALU_SEQ_MUL_EN enables the iterative OP_MUL
// (WIDTH cycles, busy high); without it OP_MUL is an undefined opcode.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake; transfer when both high
//   value1, value2       operands (value2 low SHAMT_W bits = shift amount)
//   operator             opcode (alu_seq_pkg::OP_*)
//   out_valid/out_ready  result handshake, single-entry output register
//   result, flags        registered result and {C,V,Z,N}
//   busy                 multiply in progress
//------------------------------------------------------------------------------
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] value1,
   input  logic [WIDTH-1:0] value2,
   input  logic [3:0]       operator,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             busy
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0] result_reg;
   logic [3:0]       flags_reg;
   logic             out_valid_reg;
   logic             idle;
   logic             take;

   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;

   assign in_ready  = idle && (!out_valid_reg || out_ready);
   assign take      = in_valid && in_ready;
   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign flags     = flags_reg;

`ifdef ALU_SEQ_MUL_EN
   state_t state_reg;
   state_t state_next;

   assign mul_start = take && (operator == OP_MUL);
   assign busy      = (state_reg == S_MUL);
   assign idle      = (state_reg == S_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= S_IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (mul_start) state_next = S_MUL;
         S_MUL:   if (mul_done)  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mul_start),
      .run     (busy),
      .a       (value1),
      .b       (value2),
      .done    (mul_done),
      .prod_hi (mul_hi),
      .prod_lo (mul_lo)
   );
`else
   assign mul_start = 1'b0;
   assign mul_done  = 1'b0;
   assign mul_hi    = '0;
   assign mul_lo    = '0;
   assign busy      = 1'b0;
   assign idle      = 1'b1;
`endif

   // ---------------------------------------------------------------------
   // Combinational datapath
   // ---------------------------------------------------------------------
   logic [SHAMT_W-1:0] shamt;
   logic [31:0]        shamt_ext;
   logic [WIDTH-1:0]   shl_hit;
   logic [WIDTH-1:0]   shr_hit;
   logic               shl_c;
   logic               shr_c;

   assign shamt     = value2[SHAMT_W-1:0];
   assign shamt_ext = 32'(shamt);

   // Last bit shifted out: SHL by n drops value1[WIDTH-n], SHR by n drops
   // value1[n-1]. Amounts of 0 or above WIDTH match no bit, giving C=0.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift_carry
      assign shl_hit[gi] = value1[gi] && (shamt_ext == 32'(WIDTH - gi));
      assign shr_hit[gi] = value1[gi] && (shamt_ext == 32'(gi + 1));
   end

   assign shl_c = |shl_hit;
   assign shr_c = |shr_hit;

   logic             cin;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_diff;
   logic [WIDTH-1:0] alu_r;
   logic             alu_c;
   logic             alu_v;
   logic             write_r;
   logic [3:0]       alu_flags;

   always_comb begin
      cin      = ((operator == OP_ADC) || (operator == OP_SBC)) && flags_reg[FLAG_C];
      add_sum  = {1'b0, value1} + {1'b0, value2} + {{WIDTH{1'b0}}, cin};
      // Bit WIDTH of the difference is the borrow.
      sub_diff = {1'b0, value1} - {1'b0, value2} - {{WIDTH{1'b0}}, cin};
      alu_r    = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      write_r  = 1'b1;
      case (operator)
         OP_ADD, OP_ADC: begin
            alu_r = add_sum[WIDTH-1:0];
            alu_c = add_sum[WIDTH];
            alu_v = (value1[MSB] == value2[MSB]) && (add_sum[MSB] != value1[MSB]);
         end
         OP_SUB, OP_SBC, OP_CMP: begin
            alu_r   = sub_diff[WIDTH-1:0];
            alu_c   = sub_diff[WIDTH];
            alu_v   = (value1[MSB] != value2[MSB]) && (sub_diff[MSB] != value1[MSB]);
            // CMP only sets flags; Z/N still come from the difference.
            write_r = (operator != OP_CMP);
         end
         OP_AND: alu_r = value1 & value2;
         OP_OR:  alu_r = value1 | value2;
         OP_XOR: alu_r = value1 ^ value2;
         OP_MOV: alu_r = value2;
         OP_SHL: begin
            alu_r = value1 << shamt;
            alu_c = shl_c;
         end
         OP_SHR: begin
            alu_r = value1 >> shamt;
            alu_c = shr_c;
         end
         default: ;  // undefined: r=0, so flags come out as {0,0,1,0}
      endcase
      alu_flags = pack_flags(alu_c, alu_v, (alu_r == '0), alu_r[MSB]);
   end

   // ---------------------------------------------------------------------
   // Output / flag registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result_reg    <= '0;
         flags_reg     <= '0;
         out_valid_reg <= 1'b0;
      end else if (take && !mul_start) begin
         if (write_r) result_reg <= alu_r;
         flags_reg     <= alu_flags;
         out_valid_reg <= 1'b1;
      end else if (mul_done) begin
         result_reg    <= mul_lo;
         flags_reg     <= pack_flags(mul_hi != '0, mul_hi != '0,
                                     mul_lo == '0, mul_lo[MSB]);
         out_valid_reg <= 1'b1;
      end else if (out_ready) begin
         // Also covers a MUL transfer: it needs out_ready when out_valid is set.
         out_valid_reg <= 1'b0;
      end
   end

endmodule
